// File: rtl/fp_pkg.sv
// Shared F-extension unit select codes, used by both the issue-side
// dispatch demux and the write-back result mux.
package fp_pkg;

  localparam logic [2:0] UNIT_INT = 3'd0;
  localparam logic [2:0] UNIT_ADD = 3'd1;
  localparam logic [2:0] UNIT_MUL = 3'd2;
  localparam logic [2:0] UNIT_DIV = 3'd3;
  localparam logic [2:0] UNIT_CVT = 3'd4;
  localparam logic [2:0] UNIT_CMP = 3'd5;

  localparam int NUNITS = 6;

  typedef enum logic {
    DSP_IDLE = 1'b0,
    DSP_HOLD = 1'b1
  } dsp_state_t;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel < 3'(NUNITS);
  endfunction

endpackage

// File: rtl/fp_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module fp_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fp_dispatch_demux.sv
// 1-to-6 FP issue distributor: one registered valid/ready slot whose operands
// are broadcast to all units, with a one-hot valid selecting the target unit.
module fp_dispatch_demux #(
  parameter int DW     = 32,
  parameter int RDW    = 5,
  parameter int NUNITS = fp_pkg::NUNITS,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [DW-1:0]     in_a,
  input  logic [DW-1:0]     in_b,
  input  logic [RDW-1:0]    in_rd,
  output logic [NUNITS-1:0] u_valid,
  input  logic [NUNITS-1:0] u_ready,
  output logic [DW-1:0]     u_a,
  output logic [DW-1:0]     u_b,
  output logic [RDW-1:0]    u_rd,
  output logic              err_sel,
  output logic [CNTW-1:0]   dispatch_cnt,
  output logic [CNTW-1:0]   stall_cnt
);
  import fp_pkg::*;

  dsp_state_t         state_p1, state_nxt;
  logic [2:0]         sel_p1;
  logic [DW-1:0]      a_p1, b_p1;
  logic [RDW-1:0]     rd_p1;
  logic               vld_p1;
  logic               held_rdy;
  logic               in_fire, load, dispatch_fire;

  assign vld_p1 = (state_p1 == DSP_HOLD);

  // Only the ready of the unit we are holding for matters.
  always_comb begin
    held_rdy = 1'b0;
    for (int i = 0; i < NUNITS; i++) begin
      if (sel_p1 == 3'(i)) held_rdy = u_ready[i];
    end
  end

  assign dispatch_fire = vld_p1 & held_rdy;
  assign in_ready      = ~vld_p1 | held_rdy;
  assign in_fire       = in_valid & in_ready;
  assign load          = in_fire & sel_legal(in_sel);

  always_comb begin
    state_nxt = state_p1;
    if (load) begin
      state_nxt = DSP_HOLD;
    end else if (dispatch_fire) begin
      state_nxt = DSP_IDLE;
    end
  end

  // Stage p1: output register, loaded only by a legal accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= DSP_IDLE;
      sel_p1   <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      rd_p1    <= '0;
      err_sel  <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      err_sel  <= in_fire & ~sel_legal(in_sel);
      if (load) begin
        sel_p1 <= in_sel;
        a_p1   <= in_a;
        b_p1   <= in_b;
        rd_p1  <= in_rd;
      end
    end
  end

  always_comb begin
    u_valid = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (vld_p1 && (sel_p1 == 3'(i))) u_valid[i] = 1'b1;
    end
  end

  assign u_a  = a_p1;
  assign u_b  = b_p1;
  assign u_rd = rd_p1;

  fp_sat_counter #(.W(CNTW)) u_dispatch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dispatch_fire),
    .cnt (dispatch_cnt)
  );

  fp_sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (vld_p1 & ~held_rdy),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_fp_dispatch_demux.sv
// Scoreboard bench for fp_dispatch_demux (4-bit counters so saturation is reachable).
module tb_fp_dispatch_demux;

  localparam int DW = 32, RDW = 5, NU = 6, CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_sel;
  logic [DW-1:0] in_a, in_b;
  logic [RDW-1:0] in_rd;
  logic [NU-1:0] u_valid, u_ready;
  logic [DW-1:0] u_a, u_b;
  logic [RDW-1:0] u_rd;
  logic          err_sel;
  logic [CW-1:0] dispatch_cnt, stall_cnt;

  typedef struct {
    logic [2:0]     sel;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RDW-1:0] rd;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  fp_dispatch_demux #(.DW(DW), .RDW(RDW), .NUNITS(NU), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .u_valid(u_valid), .u_ready(u_ready), .u_a(u_a), .u_b(u_b), .u_rd(u_rd),
    .err_sel(err_sel), .dispatch_cnt(dispatch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed handshake must match the oldest expected op.
  always @(negedge clk) begin
    if (!rst && u_valid != '0) begin
      checks++;
      if (!$onehot(u_valid)) begin
        errors++;
        $display("FAIL onehot u_valid=%b", u_valid);
      end
      for (int i = 0; i < NU; i++) begin
        if (u_valid[i] && u_ready[i]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected u_valid=%b u_a=%h (no op expected)", u_valid, u_a);
          end else begin
            exp_t e;
            logic [NU-1:0] ev;
            e = sbq.pop_front();
            ev = '0;
            ev[e.sel] = 1'b1;
            if (u_valid !== ev || u_a !== e.a || u_b !== e.b || u_rd !== e.rd) begin
              errors++;
              $display("FAIL sb_dispatch got v=%b a=%h b=%h rd=%0d want v=%b a=%h b=%h rd=%0d",
                       u_valid, u_a, u_b, u_rd, ev, e.a, e.b, e.rd);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] sel, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [RDW-1:0] rd,
                          input bit expect_dispatch);
    in_valid = 1'b1;
    in_sel   = sel;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    if (expect_dispatch) sbq.push_back('{sel, a, b, rd});
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0; in_rd = '0; u_ready = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (u_valid !== '0 || u_a !== '0 || u_b !== '0 || u_rd !== '0 || err_sel !== 1'b0 ||
        dispatch_cnt !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state v=%b a=%h b=%h rd=%0d err=%b dc=%0d sc=%0d rdy=%b want all zero, rdy=1",
               u_valid, u_a, u_b, u_rd, err_sel, dispatch_cnt, stall_cnt, in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    u_ready = 6'b000100;
    drive_op(3'b010, 32'h3F800000, 32'h40000000, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b000100 || u_a !== 32'h3F800000 || u_b !== 32'h40000000 || u_rd !== 5'd7) begin
      errors++;
      $display("FAIL single_out v=%b a=%h b=%h rd=%0d want 000100 3f800000 40000000 7",
               u_valid, u_a, u_b, u_rd);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dispatch_cnt !== 4'd1 || u_valid !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_after dc=%0d v=%b rdy=%b want 1 000000 1", dispatch_cnt, u_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    u_ready = '1;
    drive_op(3'b001, 32'h11111111, 32'h22222222, 5'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_rdy0 in_ready=%b want 1", in_ready);
    end
    tick();
    drive_op(3'b101, 32'h33333333, 32'h44444444, 5'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b000010 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first v=%b rdy=%b want 000010 1", u_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b100000 || u_a !== 32'h33333333) begin
      errors++; $display("FAIL b2b_second v=%b a=%h want 100000 33333333", u_valid, u_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dispatch_cnt !== 4'd2 || stall_cnt !== 4'd0 || u_valid !== '0) begin
      errors++;
      $display("FAIL b2b_counts dc=%0d sc=%0d v=%b want 2 0 000000", dispatch_cnt, stall_cnt, u_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    u_ready = 6'b110111;
    drive_op(3'b011, 32'hCAFEF00D, 32'h0BADBEEF, 5'd19, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u_ready = 6'($urandom) & 6'b110111;
      @(negedge clk);
      checks++;
      if (u_valid !== 6'b001000 || u_a !== 32'hCAFEF00D || u_rd !== 5'd19 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d v=%b a=%h rd=%0d rdy=%b want 001000 cafef00d 19 0",
                 i, u_valid, u_a, u_rd, in_ready);
      end
      tick();
    end
    u_ready = 6'b001000;
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b001000 || u_a !== 32'hCAFEF00D || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release v=%b a=%h rdy=%b want 001000 cafef00d 1", u_valid, u_a, in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd4 || dispatch_cnt !== 4'd1 || u_valid !== '0) begin
      errors++;
      $display("FAIL bp_counts sc=%0d dc=%0d v=%b want 4 1 000000", stall_cnt, dispatch_cnt, u_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    u_ready = '1;
    drive_op(3'b111, 32'hDEAD0001, 32'hDEAD0002, 5'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ill_idle_rdy in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b1 || u_valid !== '0) begin
      errors++; $display("FAIL ill_idle_pulse err=%b v=%b want 1 000000", err_sel, u_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b0 || u_valid !== '0) begin
      errors++; $display("FAIL ill_idle_clear err=%b v=%b want 0 000000", err_sel, u_valid);
    end
    u_ready = '0;
    drive_op(3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd31, 1'b1);
    tick();
    drive_op(3'b110, 32'hDEAD0003, 32'hDEAD0004, 5'd4, 1'b0);
    u_ready = 6'b000001;
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b000001 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ill_hold v=%b rdy=%b want 000001 1", u_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b1 || u_valid !== '0 || dispatch_cnt !== 4'd1 || u_a !== 32'h12345678) begin
      errors++;
      $display("FAIL ill_hold_drop err=%b v=%b dc=%0d a=%h want 1 000000 1 12345678",
               err_sel, u_valid, dispatch_cnt, u_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b0) begin
      errors++; $display("FAIL ill_hold_clear err=%b want 0", err_sel);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    u_ready = '0;
    drive_op(3'b100, 32'h55AA55AA, 32'hAA55AA55, 5'd9, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (u_valid !== 6'b010000) begin
      errors++; $display("FAIL rmh_hold v=%b want 010000", u_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_ready = '1;
    @(negedge clk);
    checks++;
    if (u_valid !== '0 || dispatch_cnt !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmh_after v=%b dc=%0d sc=%0d rdy=%b want 000000 0 0 1",
               u_valid, dispatch_cnt, stall_cnt, in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (u_valid !== '0 || dispatch_cnt !== '0) begin
      errors++; $display("FAIL rmh_nodisp v=%b dc=%0d want 000000 0", u_valid, dispatch_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    u_ready = '1;
    for (int i = 0; i < 20; i++) begin
      drive_op(3'(i % 6), $urandom, $urandom, 5'(i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (dispatch_cnt !== 4'hF || stall_cnt !== 4'h0 || u_valid !== '0) begin
      errors++;
      $display("FAIL sat_cnt dc=%h sc=%h v=%b want f 0 000000", dispatch_cnt, stall_cnt, u_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid_hold();
    test_saturation();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
